// File: rtl/ps2_cmd_pkg.sv
// Shared scan-code/ASCII constants, key classes and the set-2 to ASCII table
// for the PS/2 command assembler.
package ps2_cmd_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_BKSP  = 8'h66;
  localparam logic [7:0] SC_SPACE = 8'h29;

  localparam logic [7:0] ASCII_BS    = 8'h08;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  typedef enum logic [1:0] {NONE, PRINT, BKSP, ENTER} key_class_e;
  typedef enum logic {COLLECT, PRESENT} asm_state_e;

  // Returns 0 for anything that is not a printable key.
  function automatic logic [7:0] scan_to_ascii(input logic [7:0] sc);
    logic [7:0] a;
    case (sc)
      8'h1C: a = 8'h41;  8'h32: a = 8'h42;  8'h21: a = 8'h43;  8'h23: a = 8'h44;
      8'h24: a = 8'h45;  8'h2B: a = 8'h46;  8'h34: a = 8'h47;  8'h33: a = 8'h48;
      8'h43: a = 8'h49;  8'h3B: a = 8'h4A;  8'h42: a = 8'h4B;  8'h4B: a = 8'h4C;
      8'h3A: a = 8'h4D;  8'h31: a = 8'h4E;  8'h44: a = 8'h4F;  8'h4D: a = 8'h50;
      8'h15: a = 8'h51;  8'h2D: a = 8'h52;  8'h1B: a = 8'h53;  8'h2C: a = 8'h54;
      8'h3C: a = 8'h55;  8'h2A: a = 8'h56;  8'h1D: a = 8'h57;  8'h22: a = 8'h58;
      8'h35: a = 8'h59;  8'h1A: a = 8'h5A;
      8'h45: a = 8'h30;  8'h16: a = 8'h31;  8'h1E: a = 8'h32;  8'h26: a = 8'h33;
      8'h25: a = 8'h34;  8'h2E: a = 8'h35;  8'h36: a = 8'h36;  8'h3D: a = 8'h37;
      8'h3E: a = 8'h38;  8'h46: a = 8'h39;
      SC_SPACE: a = ASCII_SPACE;
      default: a = 8'h00;
    endcase
    return a;
  endfunction

  function automatic key_class_e classify(input logic [7:0] sc);
    key_class_e k;
    if (sc == SC_ENTER)
      k = ENTER;
    else if (sc == SC_BKSP)
      k = BKSP;
    else if (scan_to_ascii(sc) != 8'h00)
      k = PRINT;
    else
      k = NONE;
    return k;
  endfunction

endpackage

// File: rtl/ps2_scan_decoder.sv
// Strips E0/F0 prefixes (and the byte following them) and classifies make codes.
// Latency 1 cycle; no backpressure, one byte per cycle.
module ps2_scan_decoder
  import ps2_cmd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       scan_valid,
  input  logic [7:0] scan_code,
  output logic       key_valid,
  output key_class_e key_class,
  output logic [7:0] key_ascii
);

  logic ext_flag;
  logic brk_flag;

  always_ff @(posedge clk) begin
    if (reset) begin
      ext_flag  <= 1'b0;
      brk_flag  <= 1'b0;
      key_valid <= 1'b0;
      key_class <= NONE;
      key_ascii <= 8'h00;
    end else begin
      key_valid <= 1'b0;
      if (scan_valid) begin
        if (scan_code == SC_EXT) begin
          ext_flag <= 1'b1;
        end else if (scan_code == SC_BRK) begin
          brk_flag <= 1'b1;
        end else if (ext_flag || brk_flag) begin
          // Extended keys and releases are swallowed here.
          ext_flag <= 1'b0;
          brk_flag <= 1'b0;
        end else begin
          key_valid <= 1'b1;
          key_class <= classify(scan_code);
          key_ascii <= scan_to_ascii(scan_code);
        end
      end
    end
  end

endmodule

// File: rtl/ps2_command_assembler.sv
// Builds an Enter-terminated ASCII command from PS/2 keys and presents it on valid/ready.
// Latency 2 cycles scan->buffer/echo; while a command waits for cmd_ready new keys are dropped.
module ps2_command_assembler
  import ps2_cmd_pkg::*;
#(
  parameter int MAX_CHARS     = 4,
  parameter bit SHIFT_ON_FULL = 1'b1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           scan_valid,
  input  logic [7:0]                     scan_code,
  output logic                           cmd_valid,
  input  logic                           cmd_ready,
  output logic [8*MAX_CHARS-1:0]         cmd_data,
  output logic [$clog2(MAX_CHARS+1)-1:0] cmd_len,
  output logic                           overflow,
  output logic                           echo_valid,
  output logic [7:0]                     echo_char
);

  localparam int DW = 8*MAX_CHARS;
  localparam int LW = $clog2(MAX_CHARS+1);

  logic       key_valid;
  key_class_e key_class;
  logic [7:0] key_ascii;

  ps2_scan_decoder u_decoder (
    .clk        (clk),
    .reset      (reset),
    .scan_valid (scan_valid),
    .scan_code  (scan_code),
    .key_valid  (key_valid),
    .key_class  (key_class),
    .key_ascii  (key_ascii)
  );

  asm_state_e      state;
  asm_state_e      state_nxt;
  logic [DW-1:0]   data_q;
  logic [LW-1:0]   len_q;
  logic            full;
  logic            empty;
  logic [DW-1:0]   shifted_in;

  assign full       = (len_q == LW'(MAX_CHARS));
  assign empty      = (len_q == '0);
  assign shifted_in = (data_q << 8) | DW'(key_ascii);

  always_ff @(posedge clk) begin
    if (reset)
      state <= COLLECT;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      COLLECT: if (key_valid && key_class == ENTER && !empty) state_nxt = PRESENT;
      PRESENT: if (cmd_ready) state_nxt = COLLECT;
      default: state_nxt = COLLECT;
    endcase
  end

  always_comb begin
    cmd_valid = (state == PRESENT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q     <= '0;
      len_q      <= '0;
      overflow   <= 1'b0;
      echo_valid <= 1'b0;
      echo_char  <= 8'h00;
    end else begin
      echo_valid <= 1'b0;
      if (state == COLLECT && key_valid) begin
        case (key_class)
          PRINT: begin
            if (!full) begin
              data_q     <= shifted_in;
              len_q      <= len_q + LW'(1);
              echo_valid <= 1'b1;
              echo_char  <= key_ascii;
            end else begin
              overflow <= 1'b1;
              // Oldest character falls off the top of the shift.
              if (SHIFT_ON_FULL) begin
                data_q     <= shifted_in;
                echo_valid <= 1'b1;
                echo_char  <= key_ascii;
              end
            end
          end
          BKSP: begin
            if (!empty) begin
              data_q     <= data_q >> 8;
              len_q      <= len_q - LW'(1);
              echo_valid <= 1'b1;
              echo_char  <= ASCII_BS;
            end
          end
          ENTER: begin
            if (!empty) begin
              echo_valid <= 1'b1;
              echo_char  <= ASCII_CR;
            end
          end
          default: ;
        endcase
      end else if (state == PRESENT && cmd_ready) begin
        data_q   <= '0;
        len_q    <= '0;
        overflow <= 1'b0;
      end
    end
  end

  assign cmd_data = data_q;
  assign cmd_len  = len_q;

endmodule

// File: tb/tb_ps2_command_assembler.sv
// Two assemblers (shift-on-full and drop-on-full) on shared stimulus, checked every
// cycle against a character-array model plus a table of whole-command vectors.
module tb_ps2_command_assembler;

  localparam int MAXC = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scan_valid = 1'b0;
  logic [7:0] scan_code = 8'h00;
  logic       cmd_ready = 1'b0;

  // index 1: SHIFT_ON_FULL=1, index 0: SHIFT_ON_FULL=0
  logic        cmd_valid_o  [2];
  logic [31:0] cmd_data_o   [2];
  logic [2:0]  cmd_len_o    [2];
  logic        overflow_o   [2];
  logic        echo_valid_o [2];
  logic [7:0]  echo_char_o  [2];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ps2_command_assembler #(.MAX_CHARS(MAXC), .SHIFT_ON_FULL(1'b1)) dut_shift (
    .clk(clk), .reset(reset), .scan_valid(scan_valid), .scan_code(scan_code),
    .cmd_valid(cmd_valid_o[1]), .cmd_ready(cmd_ready), .cmd_data(cmd_data_o[1]),
    .cmd_len(cmd_len_o[1]), .overflow(overflow_o[1]),
    .echo_valid(echo_valid_o[1]), .echo_char(echo_char_o[1])
  );

  ps2_command_assembler #(.MAX_CHARS(MAXC), .SHIFT_ON_FULL(1'b0)) dut_drop (
    .clk(clk), .reset(reset), .scan_valid(scan_valid), .scan_code(scan_code),
    .cmd_valid(cmd_valid_o[0]), .cmd_ready(cmd_ready), .cmd_data(cmd_data_o[0]),
    .cmd_len(cmd_len_o[0]), .overflow(overflow_o[0]),
    .echo_valid(echo_valid_o[0]), .echo_char(echo_char_o[0])
  );

  // ---------------- reference model ----------------
  logic [7:0] letter_sc [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                                 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                                 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                                 8'h35, 8'h1A};
  logic [7:0] digit_sc [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                8'h3E, 8'h46};

  logic [7:0] mbuf [2][MAXC];
  int         mlen [2];
  bit         mpres [2];
  bit         movf [2];
  bit         mecho_v [2];
  logic [7:0] mecho_c [2];
  bit         m_ext, m_brk, pend_v;
  logic [7:0] pend_code;

  function automatic bit printable(input logic [7:0] sc, output logic [7:0] a);
    a = 8'h00;
    for (int i = 0; i < 26; i++) if (letter_sc[i] == sc) a = 8'(8'h41 + i);
    for (int i = 0; i < 10; i++) if (digit_sc[i] == sc) a = 8'(8'h30 + i);
    if (sc == 8'h29) a = 8'h20;
    return a != 8'h00;
  endfunction

  task automatic apply_key(input int k, input logic [7:0] sc);
    logic [7:0] a;
    if (sc == 8'h5A) begin
      if (mlen[k] > 0) begin mpres[k] = 1; mecho_v[k] = 1; mecho_c[k] = 8'h0D; end
    end else if (sc == 8'h66) begin
      if (mlen[k] > 0) begin mlen[k]--; mecho_v[k] = 1; mecho_c[k] = 8'h08; end
    end else if (printable(sc, a)) begin
      if (mlen[k] < MAXC) begin
        mbuf[k][mlen[k]] = a; mlen[k]++;
        mecho_v[k] = 1; mecho_c[k] = a;
      end else begin
        movf[k] = 1;
        if (k == 1) begin
          for (int i = 0; i < MAXC-1; i++) mbuf[k][i] = mbuf[k][i+1];
          mbuf[k][MAXC-1] = a;
          mecho_v[k] = 1; mecho_c[k] = a;
        end
      end
    end
  endtask

  task automatic model_edge();
    bit was;
    for (int k = 0; k < 2; k++) begin
      was = mpres[k];
      if (reset) begin
        mlen[k] = 0; mpres[k] = 0; movf[k] = 0; mecho_v[k] = 0; mecho_c[k] = 8'h00;
      end else begin
        mecho_v[k] = 0;
        if (pend_v && !was) apply_key(k, pend_code);
        if (was && cmd_ready) begin mlen[k] = 0; movf[k] = 0; mpres[k] = 0; end
      end
    end
    if (reset) begin
      m_ext = 0; m_brk = 0; pend_v = 0;
    end else begin
      pend_v = 0;
      if (scan_valid) begin
        if (scan_code == 8'hE0) m_ext = 1;
        else if (scan_code == 8'hF0) m_brk = 1;
        else if (m_ext || m_brk) begin m_ext = 0; m_brk = 0; end
        else begin pend_v = 1; pend_code = scan_code; end
      end
    end
  endtask

  function automatic logic [31:0] model_data(input int k);
    logic [31:0] d = 32'h0;
    for (int i = 0; i < mlen[k]; i++) d = (d << 8) | 32'(mbuf[k][i]);
    return d;
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("cmd_valid[%0d]", k), 32'(cmd_valid_o[k]), 32'(mpres[k]));
      chk($sformatf("cmd_data[%0d]", k), cmd_data_o[k], model_data(k));
      chk($sformatf("cmd_len[%0d]", k), 32'(cmd_len_o[k]), 32'(mlen[k]));
      chk($sformatf("overflow[%0d]", k), 32'(overflow_o[k]), 32'(movf[k]));
      chk($sformatf("echo_valid[%0d]", k), 32'(echo_valid_o[k]), 32'(mecho_v[k]));
      chk($sformatf("echo_char[%0d]", k), 32'(echo_char_o[k]), 32'(mecho_c[k]));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic send(input logic [7:0] b);
    scan_valid = 1'b1; scan_code = b; step();
    scan_valid = 1'b0; scan_code = 8'h00;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (cmd_valid_o[1] !== 1'b1 && n < 20) begin step(); n++; end
    chk("wait_cmd_valid", 32'(cmd_valid_o[1]), 32'd1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0]  codes [12];
    int          n;
    logic [31:0] exp_data_s;
    logic [31:0] exp_data_d;
    int          exp_len;
    bit          exp_ovf;
  } vec_t;

  vec_t vecs [5];

  initial begin
    vecs[0].codes = '{8'h1C, 8'hF0, 8'h1C, 8'h32, 8'hF0, 8'h32, 8'h5A, 8'hF0, 8'h5A, 0, 0, 0};
    vecs[0].n = 9; vecs[0].exp_data_s = 32'h4142; vecs[0].exp_data_d = 32'h4142;
    vecs[0].exp_len = 2; vecs[0].exp_ovf = 0;
    vecs[1].codes = '{8'h1C, 8'h32, 8'h66, 8'h21, 8'h5A, 0, 0, 0, 0, 0, 0, 0};
    vecs[1].n = 5; vecs[1].exp_data_s = 32'h4143; vecs[1].exp_data_d = 32'h4143;
    vecs[1].exp_len = 2; vecs[1].exp_ovf = 0;
    vecs[2].codes = '{8'h66, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h5A, 0, 0, 0, 0, 0};
    vecs[2].n = 7; vecs[2].exp_data_s = 32'h32333435; vecs[2].exp_data_d = 32'h31323334;
    vecs[2].exp_len = 4; vecs[2].exp_ovf = 1;
    vecs[3].codes = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 8'h76, 8'h1C, 8'h5A, 0, 0, 0, 0};
    vecs[3].n = 8; vecs[3].exp_data_s = 32'h41; vecs[3].exp_data_d = 32'h41;
    vecs[3].exp_len = 1; vecs[3].exp_ovf = 0;
    vecs[4].codes = '{8'h45, 8'h29, 8'h46, 8'h5A, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[4].n = 4; vecs[4].exp_data_s = 32'h302039; vecs[4].exp_data_d = 32'h302039;
    vecs[4].exp_len = 3; vecs[4].exp_ovf = 0;

    // reset state
    reset = 1'b1;
    step(); step();
    for (int k = 0; k < 2; k++) begin
      chk("reset_cmd_valid", 32'(cmd_valid_o[k]), 32'd0);
      chk("reset_cmd_data", cmd_data_o[k], 32'd0);
      chk("reset_cmd_len", 32'(cmd_len_o[k]), 32'd0);
      chk("reset_echo", 32'({echo_valid_o[k], echo_char_o[k], overflow_o[k]}), 32'd0);
    end
    reset = 1'b0;
    step();

    // table-driven whole commands, bytes back to back
    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < vecs[v].n; i++) send(vecs[v].codes[i]);
      wait_valid();
      chk($sformatf("vec%0d_data_s", v), cmd_data_o[1], vecs[v].exp_data_s);
      chk($sformatf("vec%0d_data_d", v), cmd_data_o[0], vecs[v].exp_data_d);
      chk($sformatf("vec%0d_len", v), 32'(cmd_len_o[1]), 32'(vecs[v].exp_len));
      chk($sformatf("vec%0d_ovf_s", v), 32'(overflow_o[1]), 32'(vecs[v].exp_ovf));
      chk($sformatf("vec%0d_ovf_d", v), 32'(overflow_o[0]), 32'(vecs[v].exp_ovf));
      cmd_ready = 1'b1; step(); cmd_ready = 1'b0;
      chk($sformatf("vec%0d_valid_after", v), 32'(cmd_valid_o[1]), 32'd0);
      chk($sformatf("vec%0d_len_after", v), 32'(cmd_len_o[1]), 32'd0);
      step();
    end

    // stall: command held while X,Y are typed, then transfer and a fresh A
    send(8'h1C); send(8'h5A);
    wait_valid();
    for (int c = 0; c < 10; c++) begin
      if (c == 2) scan_code = 8'h22;
      if (c == 4) scan_code = 8'h35;
      scan_valid = (c == 2 || c == 4);
      step();
      chk("stall_data", cmd_data_o[1], 32'h41);
      chk("stall_valid", 32'(cmd_valid_o[1]), 32'd1);
      chk("stall_no_echo", 32'(echo_valid_o[1]), 32'd0);
    end
    scan_valid = 1'b0;
    cmd_ready = 1'b1; step(); cmd_ready = 1'b0;
    chk("xfer_valid_low", 32'(cmd_valid_o[1]), 32'd0);
    chk("xfer_len_zero", 32'(cmd_len_o[1]), 32'd0);
    send(8'h1C); step();
    chk("post_xfer_A", cmd_data_o[1], 32'h41);
    send(8'h5A); wait_valid();
    cmd_ready = 1'b1; step(); cmd_ready = 1'b0;

    // reset while a full, overflowed command is presented
    send(8'h16); send(8'h1E); send(8'h26); send(8'h25); send(8'h2E); send(8'h5A);
    wait_valid();
    chk("pre_reset_ovf", 32'(overflow_o[0]), 32'd1);
    reset = 1'b1; step(); reset = 1'b0;
    chk("rst_present_valid", 32'(cmd_valid_o[1]), 32'd0);
    chk("rst_present_len", 32'(cmd_len_o[1]), 32'd0);
    chk("rst_present_ovf", 32'(overflow_o[1]), 32'd0);
    send(8'h32); step();
    chk("rst_then_B", cmd_data_o[1], 32'h42);

    // randomized traffic against the model
    begin
      logic [7:0] pool [14] = '{8'h1C, 8'h32, 8'h21, 8'h16, 8'h29, 8'h45, 8'h66, 8'h5A,
                                8'hE0, 8'hF0, 8'h76, 8'h75, 8'h22, 8'h35};
      for (int c = 0; c < 4000; c++) begin
        scan_valid = ($urandom_range(0, 2) != 0);
        scan_code  = pool[$urandom_range(0, 13)];
        cmd_ready  = ($urandom_range(0, 3) == 0);
        reset      = ($urandom_range(0, 699) == 0);
        step();
      end
      scan_valid = 1'b0; cmd_ready = 1'b0; reset = 1'b0;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_command_assembler.md
# ps2_command_assembler

Assembles PS/2 keyboard scan codes into a packed ASCII command word for the processor. It filters make/break and extended prefixes, maps keys to ASCII and supports backspace. A command is terminated with Enter and handed to the processor over a valid/ready handshake. It replaces the fixed 4-character, toggle-triggered character capture with a depth-parametrised buffer, a selectable overflow policy and an LCD echo stream.

## Interface
- MAX_CHARS, 4: buffer depth in characters, ≥1; command width is 8*MAX_CHARS.
- SHIFT_ON_FULL, 1: full-buffer policy. 1 = oldest character is discarded. 0 = new character is dropped.
- clk  in  1  system clock.
- reset  in  1  reset, synchronous, active-high.
- scan_valid  in  1  one-cycle pulse per received PS/2 byte.
- scan_code  in  8  received byte, qualified by scan_valid.
- cmd_valid  out  1  a completed command is presented.
- cmd_ready  in  1  processor accepts the command.
- cmd_data  out  8*MAX_CHARS  packed ASCII; newest character is in [7:0], unused upper bytes are 0.
- cmd_len  out  $clog2(MAX_CHARS+1)  number of valid characters.
- overflow  out  1  sticky; at least one character was lost in the current command.
- echo_valid  out  1  one-cycle pulse per accepted key.
- echo_char  out  8  echoed code for the LCD.

## Operation
- Prefix filter:
  - 0xE0 sets the ext flag; 0xF0 sets the brk flag.
  - The next non-prefix byte is discarded if ext or brk is set, and both flags are then cleared.
  - Extended keys and all releases therefore produce nothing.
  - The filter runs in every state.
- Key classes for accepted make codes:
  - Printable: A–Z map to 0x41–0x5A and 0–9 map to 0x30–0x39, using the standard set-2 table. Space (0x29) maps to 0x20.
  - Enter is 0x5A. Backspace is 0x66.
  - All other codes are discarded silently.
- FSM state COLLECT:
  - Printable, len<MAX_CHARS: data <= {data<<8 | ascii}, len+1, echo ascii.
  - Printable, len==MAX_CHARS:
    - SHIFT_ON_FULL=1: shift in, len unchanged, overflow<=1, echo.
    - SHIFT_ON_FULL=0: buffer unchanged, overflow<=1, no echo.
  - Backspace, len>0: data <= data>>8, len-1, echo 0x08.
  - Backspace, len==0: no effect, no echo.
  - Enter, len>0: go to PRESENT, echo 0x0D.
  - Enter, len==0: ignored, no echo.
- FSM state PRESENT:
  - cmd_valid=1; cmd_data, cmd_len and overflow are held stable.
  - Accepted keys are discarded and produce no echo.
  - When cmd_valid&&cmd_ready: data<=0, len<=0, overflow<=0, go to COLLECT.

## Timing
- Reset values: cmd_valid, cmd_data, cmd_len, overflow, echo_valid and echo_char are all 0. State is COLLECT and both prefix flags are clear.
- Latency from scan_valid to the effect:
  - The decoder registers the key: 1 cycle.
  - The buffer, echo and state update: 1 more cycle.
  - cmd_data/len and echo_valid therefore change 2 cycles after scan_valid.
  - cmd_valid rises 2 cycles after the Enter scan_valid.
- Handshake:
  - Transfer happens on the edge where cmd_valid&&cmd_ready. cmd_valid is 0 in the following cycle.
  - cmd_ready while cmd_valid=0 is ignored.
  - cmd_valid never drops without a transfer, except on reset.
- Simultaneous events: a key decoded in the transfer cycle is discarded, because the state is still PRESENT. The next key is processed normally.
- Back-to-back scan_valid on consecutive cycles is supported at full rate.
- Reset mid-operation takes effect at the next edge. A presented command is dropped and all partial state is cleared.

## Structure
- Package ps2_cmd_pkg holds:
  - Scan-code constants: 0xE0, 0xF0, 0x5A, 0x66, 0x29.
  - ASCII constants: 0x08, 0x0D, 0x20.
  - key_class enum: NONE, PRINT, BKSP, ENTER.
  - Function scan_to_ascii, the set-2 to ASCII table.
- Sub-module ps2_scan_decoder contains the prefix flags and the mapping. Its registered outputs are key_valid, key_class and key_ascii.
- The top level holds the COLLECT/PRESENT FSM, the buffer, the length counter, overflow and echo.

## Test plan
1. Input 1C,F0,1C,32,F0,32,5A,F0,5A → cmd_valid=1, cmd_len=2, cmd_data=0x00004142, echo sequence 0x41,0x42,0x0D.
2. Input A,B,Backspace,C,Enter → cmd_data=0x4143, cmd_len=2, echo includes 0x08. Backspace at len 0 → no change and no echo.
3. MAX_CHARS=4 with keys 1..5 then Enter:
   - SHIFT_ON_FULL=1 → cmd_data=0x32333435, overflow=1.
   - SHIFT_ON_FULL=0 → cmd_data=0x31323334, overflow=1, and key 5 produces no echo.
4. Hold cmd_ready=0 for 10 cycles while typing X,Y → cmd_data stays stable with no echo. Raise cmd_ready → cmd_valid=0 and cmd_len=0 the next cycle. A following key A produces cmd_data=0x41.
5. Input E0,75,E0,F0,75 (up arrow), then 0x76 (Esc) → no echo and buffer unchanged. A subsequent A is accepted.
6. Assert reset during PRESENT → the next cycle shows cmd_valid=0, cmd_len=0, overflow=0, and the FSM is in COLLECT.
